// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sb_pkg
//  Description : Shared types and constants for the streaming scoreboard
//                checker (FSM state codes, counter widths, error causes).
//  Revision    : 1.0 - initial release
// ============================================================================
package sb_pkg;

    // Checker state; codes are visible on the state output
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sb_state_e;

    // Counter widths
    localparam int c_MATCH_CNT_W = 32;
    localparam int c_ERR_CNT_W   = 16;

    // Error cause codes for debug messages
    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_MISMATCH  = 2'd1,
        ERR_UNDERFLOW = 2'd2,
        ERR_TIMEOUT   = 2'd3
    } sb_err_cause_e;

endpackage : sb_pkg
`default_nettype wire

// File: rtl/sb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sb_fifo
//  Description : Synchronous in-order FIFO holding expected words. Pointers
//                carry an extra wrap bit to tell full from empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    // Pointer update; both wrap naturally modulo 2*DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage array; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_wr_ptr - r_rd_ptr;

endmodule : sb_fifo
`default_nettype wire

// File: rtl/sb_stream_chk.sv
`default_nettype none
// ============================================================================
//  Module      : sb_stream_chk
//  Description : Streaming scoreboard. Buffers expected words in order and
//                compares each actual word against the oldest one; keeps
//                saturating match/error counts and raises a sticky finish.
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_stream_chk
    import sb_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 16,
    parameter int ERR_LIMIT    = 4,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                      sb_clk_ip,
    input  logic                      sb_rst_ip,
    input  logic                      sb_enable_ip,
    input  logic                      sb_exp_valid_ip,
    input  logic [WIDTH-1:0]          sb_exp_data_ip,
    output logic                      sb_exp_ready_op,
    input  logic                      sb_act_valid_ip,
    input  logic [WIDTH-1:0]          sb_act_data_ip,
    output logic [$clog2(DEPTH):0]    sb_level_op,
    output logic [c_MATCH_CNT_W-1:0]  sb_match_cnt_op,
    output logic [c_ERR_CNT_W-1:0]    sb_err_cnt_op,
    output logic                      sb_err_op,
    output logic [1:0]                sb_state_op,
    output logic                      sb_finish_op
);

    localparam int c_IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [c_IDLE_W-1:0]    c_IDLE_LAST = c_IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [c_ERR_CNT_W-1:0] c_ERR_LIMIT = c_ERR_CNT_W'(ERR_LIMIT);

    sb_state_e                 r_state;
    sb_state_e                 w_state_nxt;
    logic [WIDTH-1:0]          w_fifo_head;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [$clog2(DEPTH):0]    w_fifo_level;
    logic                      w_exp_ready;
    logic                      w_finish;
    logic                      w_push;
    logic                      w_act;
    logic                      w_pop;
    logic                      w_match;
    logic                      w_mismatch;
    logic                      w_underflow;
    logic                      w_timeout;
    logic                      w_err_evt;
    logic                      w_limit;
    logic [c_IDLE_W-1:0]       r_idle_cnt;
    logic [c_MATCH_CNT_W-1:0]  r_match_cnt;
    logic [c_ERR_CNT_W-1:0]    r_err_cnt;
    logic                      r_err;

    // Actual words only count while checking; pops never bypass a same-cycle push
    assign w_push      = sb_exp_valid_ip && w_exp_ready;
    assign w_act       = sb_act_valid_ip && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
    assign w_pop       = w_act && !w_fifo_empty;
    assign w_match     = w_pop && (w_fifo_head == sb_act_data_ip);
    assign w_mismatch  = w_pop && (w_fifo_head != sb_act_data_ip);
    assign w_underflow = w_act && w_fifo_empty;
    assign w_limit     = (ERR_LIMIT != 0) && (r_err_cnt >= c_ERR_LIMIT);
    assign w_timeout   = (r_state == ST_DRAIN) && !sb_act_valid_ip && !w_fifo_empty &&
                         !w_limit && (r_idle_cnt == c_IDLE_LAST);
    assign w_err_evt   = w_mismatch || w_underflow || w_timeout;

    sb_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (sb_clk_ip),
        .rst_n   (sb_rst_ip),
        .i_push  (w_push),
        .i_data  (sb_exp_data_ip),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_fifo_level)
    );

    // State register
    always_ff @(posedge sb_clk_ip or negedge sb_rst_ip) begin
        if (!sb_rst_ip) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next-state logic; error limit takes priority over the other exits
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (sb_enable_ip) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_limit)                 w_state_nxt = ST_DONE;
                else if (!sb_enable_ip && w_fifo_empty) w_state_nxt = ST_DONE;
                else if (!sb_enable_ip)      w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_limit || w_fifo_empty || w_timeout) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_DONE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        w_exp_ready = (r_state == ST_RUN) && !w_fifo_full;
        w_finish    = (r_state == ST_DONE);
    end

    // Idle timer counts DRAIN cycles without an actual word; held clear elsewhere
    always_ff @(posedge sb_clk_ip or negedge sb_rst_ip) begin
        if (!sb_rst_ip) begin
            r_idle_cnt <= '0;
        end else if ((r_state != ST_DRAIN) || sb_act_valid_ip) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != '1) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Saturating match/error counters and the one-cycle error pulse
    always_ff @(posedge sb_clk_ip or negedge sb_rst_ip) begin
        if (!sb_rst_ip) begin
            r_match_cnt <= '0;
            r_err_cnt   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_err_evt;
            if (w_match && (r_match_cnt != '1)) r_match_cnt <= r_match_cnt + 1'b1;
            if (w_err_evt && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign sb_exp_ready_op = w_exp_ready;
    assign sb_level_op     = w_fifo_level;
    assign sb_match_cnt_op = r_match_cnt;
    assign sb_err_cnt_op   = r_err_cnt;
    assign sb_err_op       = r_err;
    assign sb_state_op     = r_state;
    assign sb_finish_op    = w_finish;

endmodule : sb_stream_chk
`default_nettype wire
